// File: rtl/inst_issue_pkg.sv
// -----------------------------------------------------------------------------
// inst_issue_pkg
// Shared definitions for the dual-lane decode/issue stage: default field width
// and fetch timeout, instruction type codes, type classification helpers and
// the issue FSM state encoding.
// -----------------------------------------------------------------------------
package inst_issue_pkg;

  localparam int INS_PART_WID_DEFAULT  = 4;
  localparam int FETCH_TIMEOUT_DEFAULT = 4;

  typedef logic [INS_PART_WID_DEFAULT-1:0] part_t;

  localparam part_t TYPE_NOP   = part_t'(0);
  localparam part_t TYPE_ADD   = part_t'(1);
  localparam part_t TYPE_SUB   = part_t'(2);
  localparam part_t TYPE_MUL   = part_t'(3);
  localparam part_t TYPE_LOAD  = part_t'(4);
  localparam part_t TYPE_STORE = part_t'(5);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  function automatic logic is_legal(input part_t t);
    return t <= TYPE_STORE;
  endfunction

  // Writers set a busy bit on their dest.
  function automatic logic is_writer(input part_t t);
    return (t == TYPE_ADD) || (t == TYPE_SUB) || (t == TYPE_MUL) || (t == TYPE_LOAD);
  endfunction

  // Readers check their sources; STORE additionally reads dest.
  function automatic logic is_reader(input part_t t);
    return (t != TYPE_NOP) && is_legal(t);
  endfunction

endpackage

// File: rtl/inst_issue_unit_scoreboard.sv
// -----------------------------------------------------------------------------
// idu_scoreboard
// Register busy vector for the issue stage. Writers set the busy bit of their
// dest on the issue edge; writeback clears wb_dest; a set and clear on the
// same register in the same edge leaves it busy.
// Optional feature macro: IDU_WB_BYPASS_EN -- when defined, lookups see the
// busy vector with the current-cycle writeback already removed.
//
// Ports:
//   clk, rst       clock, async active-high reset
//   set_en[1:0]    per-lane set request, set_dest per lane
//   wb_valid       writeback strobe, wb_dest register to clear
//   rd_addr[5:0]   six read lookup addresses -> rd_busy[5:0]
//   dest_addr[1:0] two dest lookup addresses -> dest_busy[1:0]
// -----------------------------------------------------------------------------
module idu_scoreboard #(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          set_en,
  input  logic [1:0][W-1:0]   set_dest,
  input  logic                wb_valid,
  input  logic [W-1:0]        wb_dest,
  input  logic [5:0][W-1:0]   rd_addr,
  output logic [5:0]          rd_busy,
  input  logic [1:0][W-1:0]   dest_addr,
  output logic [1:0]          dest_busy
);

  localparam int N = 1 << W;

  logic [N-1:0] busy_q;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic [N-1:0] busy_chk;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < 2; i++) begin
      if (set_en[i]) set_vec[set_dest[i]] = 1'b1;
    end
    if (wb_valid) clr_vec[wb_dest] = 1'b1;
  end

  // Clear first, then OR in sets: a same-edge set wins.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) busy_q <= '0;
    else     busy_q <= (busy_q & ~clr_vec) | set_vec;
  end

`ifdef IDU_WB_BYPASS_EN
  assign busy_chk = busy_q & ~clr_vec;
`else
  assign busy_chk = busy_q;
`endif

  always_comb begin
    for (int i = 0; i < 6; i++) rd_busy[i] = busy_chk[rd_addr[i]];
    for (int i = 0; i < 2; i++) dest_busy[i] = busy_chk[dest_addr[i]];
  end

endmodule

// File: rtl/inst_issue_unit.sv
// -----------------------------------------------------------------------------
// inst_issue_unit
// Dual-lane in-order decode/issue stage. Requests an instruction pair from the
// queue, captures each lane on its first valid, checks register hazards
// against a busy scoreboard plus intra-pair dependences, and issues lane 1
// then lane 2 in program order.
// Optional feature macro: IDU_WB_BYPASS_EN (writeback bypass into the issue
// check, implemented in idu_scoreboard).
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   inst_N_fetch (out)                one-cycle fetch request per lane
//   inst_N_valid, inst_*_N (in)       queue response and fields
//   issue_ready_N (in)                execution port N can accept
//   iss_N_valid, iss_*_N (out)        issue pulse and held fields
//   wb_valid, wb_dest (in)            writeback clearing a busy bit
//   illegal_inst (out)                pulse when a captured type is undefined
// -----------------------------------------------------------------------------
module inst_issue_unit #(
  parameter int INS_PART_WID  = inst_issue_pkg::INS_PART_WID_DEFAULT,
  parameter int FETCH_TIMEOUT = inst_issue_pkg::FETCH_TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    inst_1_fetch,
  output logic                    inst_2_fetch,
  input  logic                    inst_1_valid,
  input  logic                    inst_2_valid,
  input  logic [INS_PART_WID-1:0] inst_type_1,
  input  logic [INS_PART_WID-1:0] inst_dest_1,
  input  logic [INS_PART_WID-1:0] inst_src0_1,
  input  logic [INS_PART_WID-1:0] inst_src1_1,
  input  logic [INS_PART_WID-1:0] inst_type_2,
  input  logic [INS_PART_WID-1:0] inst_dest_2,
  input  logic [INS_PART_WID-1:0] inst_src0_2,
  input  logic [INS_PART_WID-1:0] inst_src1_2,
  input  logic                    issue_ready_1,
  input  logic                    issue_ready_2,
  output logic                    iss_1_valid,
  output logic [INS_PART_WID-1:0] iss_type_1,
  output logic [INS_PART_WID-1:0] iss_dest_1,
  output logic [INS_PART_WID-1:0] iss_src0_1,
  output logic [INS_PART_WID-1:0] iss_src1_1,
  output logic                    iss_2_valid,
  output logic [INS_PART_WID-1:0] iss_type_2,
  output logic [INS_PART_WID-1:0] iss_dest_2,
  output logic [INS_PART_WID-1:0] iss_src0_2,
  output logic [INS_PART_WID-1:0] iss_src1_2,
  input  logic                    wb_valid,
  input  logic [INS_PART_WID-1:0] wb_dest,
  output logic                    illegal_inst
);
  import inst_issue_pkg::*;

  localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
  localparam int W     = INS_PART_WID;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       full_q;
  logic [W-1:0]     s_type [2];
  logic [W-1:0]     s_dest [2];
  logic [W-1:0]     s_src0 [2];
  logic [W-1:0]     s_src1 [2];

  logic [1:0]       in_valid;
  logic [W-1:0]     in_type [2];
  logic [W-1:0]     in_dest [2];
  logic [W-1:0]     in_src0 [2];
  logic [W-1:0]     in_src1 [2];

  logic [1:0] cap, legal, full_now, nop, writer, reader, store, raw_ok, waw_ok;
  logic       go_1, go_2, pair_hazard, in_issue;
  logic [5:0] rd_busy;
  logic [1:0] dest_busy;
  logic       fetch_d, illegal_d;
  logic [1:0] iss_valid_d;

  assign in_valid   = {inst_2_valid, inst_1_valid};
  assign in_type[0] = inst_type_1;
  assign in_dest[0] = inst_dest_1;
  assign in_src0[0] = inst_src0_1;
  assign in_src1[0] = inst_src1_1;
  assign in_type[1] = inst_type_2;
  assign in_dest[1] = inst_dest_2;
  assign in_src0[1] = inst_src0_2;
  assign in_src1[1] = inst_src1_2;

  // Per-lane classification and scoreboard checks.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cap[i]    = (state_q == ST_WAIT) && in_valid[i] && !full_q[i];
      legal[i]  = is_legal(in_type[i]);
      nop[i]    = (s_type[i] == TYPE_NOP);
      writer[i] = is_writer(s_type[i]);
      reader[i] = is_reader(s_type[i]);
      store[i]  = (s_type[i] == TYPE_STORE);
      raw_ok[i] = !reader[i] ||
                  !(rd_busy[3*i] || rd_busy[3*i+1] || (store[i] && rd_busy[3*i+2]));
      waw_ok[i] = !writer[i] || !dest_busy[i];
    end
  end

  assign full_now = full_q | cap;
  assign in_issue = (state_q == ST_ISSUE);

  // Lane 2 may not touch lane 1's dest when both issue on the same edge.
  assign pair_hazard = writer[0] && ((s_src0[1] == s_dest[0]) ||
                                     (s_src1[1] == s_dest[0]) ||
                                     (s_dest[1] == s_dest[0]));

  assign go_1 = in_issue && full_q[0] &&
                (nop[0] || (issue_ready_1 && raw_ok[0] && waw_ok[0]));
  assign go_2 = in_issue && full_q[1] && (!full_q[0] || go_1) &&
                (nop[1] || (issue_ready_2 && raw_ok[1] && waw_ok[1] &&
                            !(go_1 && pair_hazard)));

  idu_scoreboard #(.W(W)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    ({go_2 && writer[1], go_1 && writer[0]}),
    .set_dest  ({s_dest[1], s_dest[0]}),
    .wb_valid  (wb_valid),
    .wb_dest   (wb_dest),
    .rd_addr   ({s_dest[1], s_src1[1], s_src0[1], s_dest[0], s_src1[0], s_src0[0]}),
    .rd_busy   (rd_busy),
    .dest_addr ({s_dest[1], s_dest[0]}),
    .dest_busy (dest_busy)
  );

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (&full_now)                          state_d = ST_ISSUE;
        else if (cnt_q == CNT_W'(FETCH_TIMEOUT)) state_d = (|full_now) ? ST_ISSUE : ST_FETCH;
      end
      ST_ISSUE: begin
        if (!(full_q[0] && !go_1) && !(full_q[1] && !go_2)) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // FSM: outputs (registered below so every output is 0 in reset).
  always_comb begin
    fetch_d     = (state_q == ST_FETCH);
    iss_valid_d = {go_2 && !nop[1], go_1 && !nop[0]};
    illegal_d   = |(cap & ~legal);
  end

  // Wait counter and slot occupancy. An empty slot counts as already issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      full_q <= '0;
    end else begin
      cnt_q <= (state_d == ST_WAIT) ? cnt_q + CNT_W'(1) : '0;
      unique case (state_q)
        ST_WAIT:  full_q <= full_now;
        ST_ISSUE: full_q <= full_q & ~{go_2, go_1};
        default:  full_q <= '0;
      endcase
    end
  end

  // NOTE: slot payload is only meaningful while its full bit is set, so it
  // carries no reset; full_q alone defines slot occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cap[i]) begin
        s_type[i] <= legal[i] ? in_type[i] : TYPE_NOP;
        s_dest[i] <= in_dest[i];
        s_src0[i] <= in_src0[i];
        s_src1[i] <= in_src1[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_1_fetch <= 1'b0;
      inst_2_fetch <= 1'b0;
      illegal_inst <= 1'b0;
      iss_1_valid  <= 1'b0;
      iss_2_valid  <= 1'b0;
      iss_type_1   <= '0;
      iss_dest_1   <= '0;
      iss_src0_1   <= '0;
      iss_src1_1   <= '0;
      iss_type_2   <= '0;
      iss_dest_2   <= '0;
      iss_src0_2   <= '0;
      iss_src1_2   <= '0;
    end else begin
      inst_1_fetch <= fetch_d;
      inst_2_fetch <= fetch_d;
      illegal_inst <= illegal_d;
      iss_1_valid  <= iss_valid_d[0];
      iss_2_valid  <= iss_valid_d[1];
      if (iss_valid_d[0]) begin
        iss_type_1 <= s_type[0];
        iss_dest_1 <= s_dest[0];
        iss_src0_1 <= s_src0[0];
        iss_src1_1 <= s_src1[0];
      end
      if (iss_valid_d[1]) begin
        iss_type_2 <= s_type[1];
        iss_dest_2 <= s_dest[1];
        iss_src0_2 <= s_src0[1];
        iss_src1_2 <= s_src1[1];
      end
    end
  end

endmodule

// File: tb/tb_inst_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_issue_unit
// Directed self-checking bench for inst_issue_unit. Expected values are
// hand-computed; writeback-bypass timing follows IDU_WB_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_inst_issue_unit;

  localparam int W = 4;
`ifdef IDU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         inst_1_fetch, inst_2_fetch;
  logic         inst_1_valid, inst_2_valid;
  logic [W-1:0] inst_type_1, inst_dest_1, inst_src0_1, inst_src1_1;
  logic [W-1:0] inst_type_2, inst_dest_2, inst_src0_2, inst_src1_2;
  logic         issue_ready_1, issue_ready_2;
  logic         iss_1_valid, iss_2_valid;
  logic [W-1:0] iss_type_1, iss_dest_1, iss_src0_1, iss_src1_1;
  logic [W-1:0] iss_type_2, iss_dest_2, iss_src0_2, iss_src1_2;
  logic         wb_valid;
  logic [W-1:0] wb_dest;
  logic         illegal_inst;

  int n_checks = 0;
  int n_errors = 0;

  inst_issue_unit dut (
    .clk           (clk),
    .rst           (rst),
    .inst_1_fetch  (inst_1_fetch),
    .inst_2_fetch  (inst_2_fetch),
    .inst_1_valid  (inst_1_valid),
    .inst_2_valid  (inst_2_valid),
    .inst_type_1   (inst_type_1),
    .inst_dest_1   (inst_dest_1),
    .inst_src0_1   (inst_src0_1),
    .inst_src1_1   (inst_src1_1),
    .inst_type_2   (inst_type_2),
    .inst_dest_2   (inst_dest_2),
    .inst_src0_2   (inst_src0_2),
    .inst_src1_2   (inst_src1_2),
    .issue_ready_1 (issue_ready_1),
    .issue_ready_2 (issue_ready_2),
    .iss_1_valid   (iss_1_valid),
    .iss_type_1    (iss_type_1),
    .iss_dest_1    (iss_dest_1),
    .iss_src0_1    (iss_src0_1),
    .iss_src1_1    (iss_src1_1),
    .iss_2_valid   (iss_2_valid),
    .iss_type_2    (iss_type_2),
    .iss_dest_2    (iss_dest_2),
    .iss_src0_2    (iss_src0_2),
    .iss_src1_2    (iss_src1_2),
    .wb_valid      (wb_valid),
    .wb_dest       (wb_dest),
    .illegal_inst  (illegal_inst)
  );

  always #5 clk = ~clk;

  logic [15:0] busy;
  assign busy = dut.u_scoreboard.busy_q;

  logic [36:0] all_outs;
  assign all_outs = {inst_1_fetch, inst_2_fetch, iss_1_valid, iss_2_valid, illegal_inst,
                     iss_type_1, iss_dest_1, iss_src0_1, iss_src1_1,
                     iss_type_2, iss_dest_2, iss_src0_2, iss_src1_2};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the fetch strobes, then returns the pair one cycle
  // later so it is captured on the next edge. Returns #1 after that edge.
  task automatic deliver(input logic v1, input logic [W-1:0] t1, d1, a1, b1,
                         input logic v2, input logic [W-1:0] t2, d2, a2, b2);
    bit seen;
    seen = inst_1_fetch && inst_2_fetch;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      seen = inst_1_fetch && inst_2_fetch;
    end
    check("fetch_seen", 64'(seen), 64'(1));
    @(posedge clk); #1;
    check("fetch_pulse_width", 64'({inst_1_fetch, inst_2_fetch}), 64'(0));
    inst_1_valid = v1; inst_type_1 = t1; inst_dest_1 = d1; inst_src0_1 = a1; inst_src1_1 = b1;
    inst_2_valid = v2; inst_type_2 = t2; inst_dest_2 = d2; inst_src0_2 = a2; inst_src1_2 = b2;
    @(posedge clk); #1;
    inst_1_valid = 1'b0;
    inst_2_valid = 1'b0;
  endtask

  task automatic wb_pulse(input logic [W-1:0] d);
    wb_valid = 1'b1;
    wb_dest  = d;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit any_iss;
    rst = 1'b1;
    inst_1_valid = 1'b0; inst_2_valid = 1'b0;
    inst_type_1 = '0; inst_dest_1 = '0; inst_src0_1 = '0; inst_src1_1 = '0;
    inst_type_2 = '0; inst_dest_2 = '0; inst_src0_2 = '0; inst_src1_2 = '0;
    issue_ready_1 = 1'b1; issue_ready_2 = 1'b1;
    wb_valid = 1'b0; wb_dest = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'(all_outs), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("fetch_after_reset", 64'({inst_1_fetch, inst_2_fetch}), 64'(2'b11));

    // Pair without hazards: ADD r1,r2,r3 / SUB r4,r5,r6 issue together.
    deliver(1'b1, 4'd1, 4'd1, 4'd2, 4'd3, 1'b1, 4'd2, 4'd4, 4'd5, 4'd6);
    @(posedge clk); #1;
    check("pair_valids", 64'({iss_1_valid, iss_2_valid}), 64'(2'b11));
    check("pair_fields_1", 64'({iss_type_1, iss_dest_1, iss_src0_1, iss_src1_1}), 64'(16'h1123));
    check("pair_fields_2", 64'({iss_type_2, iss_dest_2, iss_src0_2, iss_src1_2}), 64'(16'h2456));
    check("pair_busy", 64'(busy), 64'(16'h0012));
    @(posedge clk); #1;
    check("pair_pulse_end", 64'({iss_1_valid, iss_2_valid}), 64'(0));
    check("pair_fields_held", 64'(iss_dest_2), 64'(4));
    check("refetch_after_pair", 64'({inst_1_fetch, inst_2_fetch}), 64'(2'b11));
    wb_pulse(4'd1);
    wb_pulse(4'd4);
    check("wb_cleared", 64'(busy), 64'(0));

    // Intra-pair RAW: ADD r1,r2,r3 / ADD r7,r1,r0; writeback of r1 releases lane 2.
    deliver(1'b1, 4'd1, 4'd1, 4'd2, 4'd3, 1'b1, 4'd1, 4'd7, 4'd1, 4'd0);
    @(posedge clk); #1;
    check("raw_lane1_only", 64'({iss_1_valid, iss_2_valid}), 64'(2'b10));
    check("raw_busy_r1", 64'(busy), 64'(16'h0002));
    wb_valid = 1'b1; wb_dest = 4'd1;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    check("raw_lane2_step1", 64'(iss_2_valid), 64'(BYP));
    @(posedge clk); #1;
    check("raw_lane2_step2", 64'(iss_2_valid), 64'(!BYP));
    check("raw_lane2_fields", 64'({iss_dest_2, iss_src0_2}), 64'(8'h71));
    check("raw_busy_r7", 64'(busy), 64'(16'h0080));
    wb_pulse(4'd7);

    // Only lane 1 returns: timeout after 4 WAIT cycles, lane 1 issues alone.
    deliver(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(posedge clk); #1;
    check("timeout_wait_a", 64'(iss_1_valid), 64'(0));
    @(posedge clk); #1;
    check("timeout_wait_b", 64'(iss_1_valid), 64'(0));
    @(posedge clk); #1;
    check("timeout_issue", 64'({iss_1_valid, iss_2_valid}), 64'(2'b10));
    check("timeout_dest", 64'(iss_dest_1), 64'(2));
    @(posedge clk); #1;
    check("timeout_refetch", 64'({inst_1_fetch, inst_2_fetch}), 64'(2'b11));
    wb_pulse(4'd2);

    // Illegal type 9 on lane 1: pulse once, lane 1 retires as NOP, lane 2 issues.
    deliver(1'b1, 4'd9, 4'd1, 4'd2, 4'd3, 1'b1, 4'd2, 4'd5, 4'd6, 4'd8);
    check("illegal_pulse", 64'(illegal_inst), 64'(1));
    @(posedge clk); #1;
    check("illegal_once", 64'(illegal_inst), 64'(0));
    check("illegal_valids", 64'({iss_1_valid, iss_2_valid}), 64'(2'b01));
    check("illegal_lane2", 64'({iss_type_2, iss_dest_2, iss_src0_2, iss_src1_2}), 64'(16'h2568));
    check("illegal_lane1_held", 64'({iss_type_1, iss_dest_1}), 64'(8'h12));
    check("illegal_busy", 64'(busy), 64'(16'h0020));
    wb_pulse(4'd5);

    // Set and clear of r3 on the same edge: set wins.
    deliver(1'b1, 4'd1, 4'd3, 4'd0, 4'd0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    @(posedge clk); #1;
    check("r3_writer", 64'({iss_1_valid, iss_2_valid}), 64'(2'b10));
    check("r3_busy", 64'(busy), 64'(16'h0008));
    deliver(1'b1, 4'd2, 4'd3, 4'd1, 4'd2, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    wb_valid = 1'b1; wb_dest = 4'd3;
    @(posedge clk); #1;
    wb_valid = BYP ? 1'b0 : 1'b1;
    check("same_edge_step1", 64'(iss_1_valid), 64'(BYP));
    check("same_edge_busy1", 64'(busy), 64'(BYP ? 16'h0008 : 16'h0000));
    @(posedge clk); #1;
    wb_valid = 1'b0;
    check("same_edge_step2", 64'(iss_1_valid), 64'(!BYP));
    check("set_wins", 64'(busy), 64'(16'h0008));

    // Reset while in ISSUE with r2 busy and lane 2 stalled.
    deliver(1'b1, 4'd1, 4'd2, 4'd0, 4'd0, 1'b1, 4'd1, 4'd9, 4'd2, 4'd0);
    @(posedge clk); #1;
    check("pre_rst_valids", 64'({iss_1_valid, iss_2_valid}), 64'(2'b10));
    check("pre_rst_busy", 64'(busy), 64'(16'h000C));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", 64'(all_outs), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("fetch_after_mid_rst", 64'({inst_1_fetch, inst_2_fetch}), 64'(2'b11));
    any_iss = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      any_iss = any_iss | iss_1_valid | iss_2_valid;
    end
    check("no_issue_after_rst", 64'(any_iss), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
